// File: rtl/huffman_pkg.sv
// Shared types and width helpers for the Huffman stream encoder.
// Widths derived from the top-level parameters live here as functions so every file agrees.
package huffman_pkg;

  localparam int DEF_SYM_W   = 4;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_OUT_W   = 8;

  // Table entries are stored at the widest legal code length (16 bits).
  localparam int CODE_MAX_W = 16;
  localparam int LEN_MAX_W  = 5;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int acc_w(input int out_w, input int max_len);
    return out_w + max_len;
  endfunction

  function automatic int fill_w(input int acc_width);
    return $clog2(acc_width + 1);
  endfunction

  localparam int LEN_W = len_w(DEF_MAX_LEN);
  localparam int ACC_W = acc_w(DEF_OUT_W, DEF_MAX_LEN);

  typedef enum logic {
    ENC   = 1'b0,
    FLUSH = 1'b1
  } mode_e;

  typedef struct packed {
    logic [LEN_MAX_W-1:0]  len;
    logic [CODE_MAX_W-1:0] code;
  } tbl_ent_t;

endpackage

// File: rtl/huffman_code_table.sv
// Programmable code table: register array, one write port, combinational read.
// A write lands at the clock edge, so a same-cycle read of that address returns the old entry.
module huffman_code_table
  import huffman_pkg::*;
#(
  parameter int SYM_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [SYM_W-1:0] waddr,
  input  tbl_ent_t         wdata,
  input  logic [SYM_W-1:0] raddr,
  output tbl_ent_t         rdata
);

  localparam int DEPTH = 2 ** SYM_W;

  tbl_ent_t mem_q [DEPTH];
  tbl_ent_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/huffman_stream_encoder.sv
// Huffman encoder core: symbol lookup, MSB-first bit packer and ENC/FLUSH control.
// Optional symbol/bit counters are built when HUFF_STATS_EN is defined.
module huffman_stream_encoder
  import huffman_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         tbl_we,
  input  logic [SYM_W-1:0]             tbl_addr,
  input  logic [MAX_LEN-1:0]           tbl_code,
  input  logic [$clog2(MAX_LEN+1)-1:0] tbl_len,
  input  logic                         sym_valid,
  output logic                         sym_ready,
  input  logic [SYM_W-1:0]             sym_data,
  input  logic                         flush_req,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic                         out_last,
  output logic                         flush_done,
  output logic                         err_nocode,
`ifdef HUFF_STATS_EN
  input  logic                         stat_clr,
  output logic [15:0]                  stat_syms,
  output logic [23:0]                  stat_bits,
`endif
  input  logic                         err_clr
);

  localparam int AW = acc_w(OUT_W, MAX_LEN);
  localparam int FW = fill_w(AW);

  mode_e           mode_q, mode_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            flush_done_q, flush_done_d;
  logic            err_q, err_d;

  tbl_ent_t        rd_ent, wr_ent;
  logic            push, pop;
  logic [FW-1:0]   pop_cnt, fill_mid;
  logic [AW-1:0]   acc_mid;
  logic [CODE_MAX_W-1:0] code_m;
  int              sh;

  assign wr_ent.len  = LEN_MAX_W'(tbl_len);
  assign wr_ent.code = CODE_MAX_W'(tbl_code);

  huffman_code_table #(.SYM_W(SYM_W)) u_tbl (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tbl_we & ena),
    .waddr (tbl_addr),
    .wdata (wr_ent),
    .raddr (sym_data),
    .rdata (rd_ent)
  );

  // Ready and valid depend on registered state only; no path from out_ready.
  assign sym_ready  = rst_n & ena & (mode_q == ENC) & (fill_q <= FW'(OUT_W));
  assign out_valid  = (fill_q >= FW'(OUT_W)) | ((mode_q == FLUSH) & (fill_q != '0));
  assign out_data   = acc_q[AW-1 -: OUT_W];
  assign out_last   = (mode_q == FLUSH) & (fill_q != '0) & (fill_q <= FW'(OUT_W));
  assign flush_done = flush_done_q;
  assign err_nocode = err_q;

  assign push = sym_valid & sym_ready;
  assign pop  = out_valid & out_ready & ena;

  always_comb begin
    acc_d        = acc_q;
    fill_d       = fill_q;
    mode_d       = mode_q;
    flush_done_d = 1'b0;
    err_d        = err_q;

    pop_cnt  = (fill_q >= FW'(OUT_W)) ? FW'(OUT_W) : fill_q;
    fill_mid = pop ? (fill_q - pop_cnt) : fill_q;
    acc_mid  = pop ? (acc_q << pop_cnt) : acc_q;

    // Code lands directly below the surviving bits; bits under fill stay zero.
    code_m = rd_ent.code & ~({CODE_MAX_W{1'b1}} << rd_ent.len);
    sh     = AW - int'(fill_mid) - int'(rd_ent.len);

    acc_d  = acc_mid;
    fill_d = fill_mid;
    if (push) begin
      acc_d  = acc_mid | (AW'(code_m) << sh);
      fill_d = fill_mid + FW'(rd_ent.len);
      if (rd_ent.len == '0) err_d = 1'b1;
    end
    if (ena & err_clr) err_d = 1'b0;

    case (mode_q)
      ENC: begin
        if (ena & flush_req) begin
          if (fill_d == '0) flush_done_d = 1'b1;
          else              mode_d       = FLUSH;
        end
      end
      FLUSH: begin
        if (pop & (fill_d == '0)) begin
          mode_d       = ENC;
          flush_done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= ENC;
      acc_q        <= '0;
      fill_q       <= '0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_done_q <= flush_done_d;
      err_q        <= err_d;
    end
  end

`ifdef HUFF_STATS_EN
  logic [15:0] stat_syms_q, stat_syms_d;
  logic [23:0] stat_bits_q, stat_bits_d;
  logic [24:0] bits_sum;

  always_comb begin
    stat_syms_d = stat_syms_q;
    stat_bits_d = stat_bits_q;
    bits_sum    = {1'b0, stat_bits_q} + 25'(rd_ent.len);
    if (push) begin
      if (stat_syms_q != '1) stat_syms_d = stat_syms_q + 16'd1;
      stat_bits_d = bits_sum[24] ? '1 : bits_sum[23:0];
    end
    if (ena & stat_clr) begin
      stat_syms_d = '0;
      stat_bits_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_syms_q <= '0;
      stat_bits_q <= '0;
    end else begin
      stat_syms_q <= stat_syms_d;
      stat_bits_q <= stat_bits_d;
    end
  end

  assign stat_syms = stat_syms_q;
  assign stat_bits = stat_bits_q;
`endif

endmodule

// File: tb/tb_huffman_stream_encoder.sv
// Directed bench for huffman_stream_encoder: encode, backpressure, no-code, flush, table hazard, reset.
module tb_huffman_stream_encoder;

  logic       clk = 1'b0;
  logic       rst_n, ena, tbl_we;
  logic [3:0] tbl_addr;
  logic [7:0] tbl_code;
  logic [3:0] tbl_len;
  logic       sym_valid, sym_ready;
  logic [3:0] sym_data;
  logic       flush_req, out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_last, flush_done, err_nocode, err_clr;

  int checks = 0;
  int errors = 0;
  int cyc = 0, word_cyc = 0, fd_cyc = 0, fd_cnt = 0;
  int n;
  logic [8:0] wq[$];

  huffman_stream_encoder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code), .tbl_len(tbl_len),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
    .flush_req(flush_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .flush_done(flush_done),
    .err_nocode(err_nocode), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Words and flush pulses are recorded half a cycle before the edge that consumes them.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && ena && out_valid && out_ready) begin
      wq.push_back({out_last, out_data});
      word_cyc = cyc;
    end
    if (flush_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_cycles(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wr_tbl(input logic [3:0] a, input logic [7:0] c, input logic [3:0] l);
    tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
    step();
    tbl_we = 1'b0;
  endtask

  task automatic send_sym(input logic [3:0] s);
    sym_valid = 1'b1; sym_data = s;
    #1;
    for (int i = 0; i < 50 && !sym_ready; i++) step();
    chk("send_sym_ready_timeout", {31'd0, sym_ready}, 32'd1);
    step();
    sym_valid = 1'b0;
  endtask

  task automatic flush();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0;
    sym_valid = 1'b0; sym_data = '0; flush_req = 1'b0; out_ready = 1'b0; err_clr = 1'b0;

    // Reset state
    #12;
    chk("rst_sym_ready", {31'd0, sym_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
    chk("rst_err", {31'd0, err_nocode}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    step();

    // Basic encode: 0 10 110 111 -> 0x5B then 0x80 (last)
    wr_tbl(4'd0, 8'h00, 4'd1);
    wr_tbl(4'd1, 8'h02, 4'd2);
    wr_tbl(4'd2, 8'h06, 4'd3);
    wr_tbl(4'd3, 8'h07, 4'd3);
    wr_tbl(4'd7, 8'h05, 4'd3);
    out_ready = 1'b1;
    wq.delete();
    send_sym(4'd0); send_sym(4'd1); send_sym(4'd2); send_sym(4'd3);
    flush();
    wait_cycles(4);
    chk("enc_words", wq.size(), 32'd2);
    if (wq.size() == 2) begin
      chk("enc_w0", {23'd0, wq[0]}, 32'h05B);
      chk("enc_w1", {23'd0, wq[1]}, 32'h180);
    end
    chk("enc_fd_cnt", fd_cnt, 32'd1);
    chk("enc_fd_timing", fd_cyc, word_cyc + 1);

    // Backpressure: nine 1-bit symbols fill to 9, then input stalls
    wq.delete();
    out_ready = 1'b0;
    sym_valid = 1'b1; sym_data = 4'd0;
    #1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (sym_ready) n++;
      step();
    end
    chk("bp_accepts", n, 32'd9);
    chk("bp_sym_ready", {31'd0, sym_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_out_data", {24'd0, out_data}, 32'h00);
    wait_cycles(3);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_data", {24'd0, out_data}, 32'h00);
    chk("bp_no_pop", wq.size(), 32'd0);
    out_ready = 1'b1;
    send_sym(4'd3);
    flush();
    wait_cycles(5);
    chk("bp_words", wq.size(), 32'd2);
    if (wq.size() == 2) begin
      chk("bp_w0", {23'd0, wq[0]}, 32'h000);
      chk("bp_w1", {23'd0, wq[1]}, 32'h170);
    end

    // No-code symbol, sticky error, clear and clear-over-set priority
    wq.delete();
    send_sym(4'd5);
    #1 chk("nc_err_set", {31'd0, err_nocode}, 32'd1);
    send_sym(4'd1); send_sym(4'd1); send_sym(4'd1); send_sym(4'd1);
    wait_cycles(3);
    chk("nc_words", wq.size(), 32'd1);
    if (wq.size() == 1) chk("nc_w0", {23'd0, wq[0]}, 32'h0AA);
    chk("nc_err_sticky", {31'd0, err_nocode}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    #1 chk("nc_err_clr", {31'd0, err_nocode}, 32'd0);
    err_clr = 1'b1;
    send_sym(4'd5);
    err_clr = 1'b0;
    #1 chk("nc_clr_priority", {31'd0, err_nocode}, 32'd0);

    // Empty flush: pulse next cycle, no word
    wq.delete();
    flush_req = 1'b1;
    @(posedge clk); #2;
    flush_req = 1'b0;
    #1;
    chk("ef_done_pulse", {31'd0, flush_done}, 32'd1);
    chk("ef_no_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("ef_done_low", {31'd0, flush_done}, 32'd0);
    chk("ef_no_words", wq.size(), 32'd0);

    // Write/lookup hazard: old "101" used, then eight ones -> 0xBF, 0xE0 (last)
    wq.delete();
    sym_valid = 1'b1; sym_data = 4'd7;
    tbl_we = 1'b1; tbl_addr = 4'd7; tbl_code = 8'hFF; tbl_len = 4'd8;
    #1 chk("hz_ready", {31'd0, sym_ready}, 32'd1);
    step();
    sym_valid = 1'b0; tbl_we = 1'b0;
    send_sym(4'd7);
    flush();
    wait_cycles(5);
    chk("hz_words", wq.size(), 32'd2);
    if (wq.size() == 2) begin
      chk("hz_w0", {23'd0, wq[0]}, 32'h0BF);
      chk("hz_w1", {23'd0, wq[1]}, 32'h1E0);
    end

    // Concurrent push and pop at fill 8 keeps fill at 8
    wq.delete();
    sym_valid = 1'b1; sym_data = 4'd7;
    #1 chk("pp_ready0", {31'd0, sym_ready}, 32'd1);
    step();
    #1;
    chk("pp_fill8", {27'd0, dut.fill_q}, 32'd8);
    chk("pp_ready8", {31'd0, sym_ready}, 32'd1);
    chk("pp_valid8", {31'd0, out_valid}, 32'd1);
    step();
    sym_valid = 1'b0;
    #1 chk("pp_fill_after", {27'd0, dut.fill_q}, 32'd8);
    wait_cycles(3);
    chk("pp_words", wq.size(), 32'd2);
    if (wq.size() == 2) begin
      chk("pp_w0", {23'd0, wq[0]}, 32'h0FF);
      chk("pp_w1", {23'd0, wq[1]}, 32'h0FF);
    end

    // Reset mid-operation at fill 5
    wq.delete();
    out_ready = 1'b0;
    send_sym(4'd5); send_sym(4'd2); send_sym(4'd1);
    #1 chk("mr_pre_fill", {27'd0, dut.fill_q}, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_fill", {27'd0, dut.fill_q}, 32'd0);
    chk("mr_err", {31'd0, err_nocode}, 32'd0);
    chk("mr_sym_ready", {31'd0, sym_ready}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    send_sym(4'd1);
    #1 chk("mr_tbl_cleared", {31'd0, err_nocode}, 32'd1);
    chk("mr_valid_after", {31'd0, out_valid}, 32'd0);
    flush();
    #1 chk("mr_flush_done", {31'd0, flush_done}, 32'd1);
    wait_cycles(3);
    chk("mr_no_words", wq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
